uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmitter with configurable data width, parity and stop bits, fed by a small internal FIFO through a valid/ready handshake. Frames are sent back-to-back with no idle gap while the FIFO holds data. Sits between the processor's memory-mapped UART register block and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed UART transmitter; optional CTS flow control when UART_TX_CTS_EN is defined
module uart_tx_fifo #(
  parameter int UART_BAUD  = 921600,
  parameter int CLK_RATE   = 12500000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef UART_TX_CTS_EN
  input  logic                            uart_cts_n,
`endif
  output logic                            uart_tx,
  input  logic [DATA_BITS-1:0]            uart_tx_data,
  input  logic                            uart_tx_valid,
  output logic                            uart_tx_ready,
  output logic                            uart_tx_busy,
  output logic                            uart_tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] uart_tx_count
);
  localparam int CLKS_PER_BIT = CLK_RATE / UART_BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLK_RATE / UART_BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
      $error("uart_tx_fifo: unsupported frame format");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, push, pop, send_ok, can_start;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit, tx_next;
  logic                 bit_end, last_data, last_stop, frame_end;

  assign full          = (uart_tx_count == CW'(FIFO_DEPTH));
  assign push          = uart_tx_valid && !full;
  assign uart_tx_ready = !full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      uart_tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   uart_tx_count <= uart_tx_count + 1'b1;
        2'b01:   uart_tx_count <= uart_tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_tx_data;
  end

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Comes out of reset as "not clear" so nothing is sent before the pin is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cts_sync <= 2'b11;
    else      cts_sync <= {cts_sync[0], uart_cts_n};
  end
  assign send_ok = !cts_sync[1];
`else
  assign send_ok = 1'b1;
`endif

  assign can_start = (uart_tx_count != '0) && send_ok;
  assign bit_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign frame_end = (state == S_STOP) && bit_end && last_stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_start) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START:  if (bit_end) state_next = S_DATA;
      S_DATA:   if (bit_end && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_next = S_STOP;
      S_STOP: begin
        if (frame_end) begin
          if (can_start) begin
            state_next = S_START;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (bit_end && (state == S_DATA || state == S_STOP)) begin
        if ((state == S_DATA && last_data) || (state == S_STOP && last_stop)) bit_cnt <= '0;
        else                                                                  bit_cnt <= bit_cnt + 1'b1;
      end
      if (pop) begin
        shift   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
      end else if (state == S_DATA && bit_end) begin
        shift <= shift >> 1;
      end
    end
  end

  // Line value is chosen from the state being entered so the pin flop lines up with it
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = (state == S_DATA && bit_end) ? shift[1] : shift[0];
      S_PARITY: tx_next = par_bit;
      default:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_tx      <= 1'b1;
      uart_tx_done <= 1'b0;
    end else begin
      uart_tx      <= tx_next;
      uart_tx_done <= frame_end;
    end
  end

  assign uart_tx_busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo: vector table, corner sequences, random traffic vs frame model
module tb_uart_tx_fifo;
  localparam int CPB   = 12500000 / 921600;
  localparam int FLEN0 = (1 + 8 + 0 + 1) * CPB;
  localparam int FLEN1 = (1 + 7 + 1 + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v0 = 1'b0;
  logic [7:0] d0 = '0;
  logic       v1 = 1'b0;
  logic [6:0] d1 = '0;
  logic       tx0, rdy0, busy0, done0;
  logic [2:0] cnt0;
  logic       tx1, rdy1, busy1, done1;
  logic [1:0] cnt1;
`ifdef UART_TX_CTS_EN
  logic       cts0 = 1'b0;
  logic       cts1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0;
  int done1_cnt = 0;

  logic [7:0] q[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [9:0] m_fr = '0;
  bit         m_done = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  uart_tx_fifo u_dut0 (
    .clk           (clk),
    .rst           (rst),
`ifdef UART_TX_CTS_EN
    .uart_cts_n    (cts0),
`endif
    .uart_tx       (tx0),
    .uart_tx_data  (d0),
    .uart_tx_valid (v0),
    .uart_tx_ready (rdy0),
    .uart_tx_busy  (busy0),
    .uart_tx_done  (done0),
    .uart_tx_count (cnt0)
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
`ifdef UART_TX_CTS_EN
    .uart_cts_n    (cts1),
`endif
    .uart_tx       (tx1),
    .uart_tx_data  (d1),
    .uart_tx_valid (v1),
    .uart_tx_ready (rdy1),
    .uart_tx_busy  (busy1),
    .uart_tx_done  (done1),
    .uart_tx_count (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a queue of characters and a position inside the frame on the line
  task automatic model_update();
    bit         accept, fin;
    logic [7:0] c;
    if (!rst) begin
      q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_done   = 1'b0;
      return;
    end
    accept = v0 && (q.size() < 4);
    fin    = m_active && (m_t == FLEN0 - 1);
    m_done = fin;
    if (!m_active || fin) begin
      if (q.size() > 0) begin
        c        = q.pop_front();
        m_fr     = {1'b1, c, 1'b0};
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_t++;
    end
    if (accept) q.push_back(d0);
  endtask

  task automatic step();
    logic exp_tx;
    @(posedge clk);
    model_update();
    @(negedge clk);
    exp_tx = m_active ? m_fr[m_t / CPB] : 1'b1;
    chk("tx0", tx0, exp_tx);
    chk("ready0", rdy0, q.size() < 4);
    chk("busy0", busy0, m_active);
    chk("done0", done0, m_done);
    chk("count0", cnt0, q.size());
    if (done0 === 1'b1) done0_cnt++;
    if (done1 === 1'b1) done1_cnt++;
  endtask

  // Entered right after the edge where the line fell; samples mid-bit and returns the offset of done
  task automatic capture(input int which, input int nbits, output logic [15:0] cap, output int off);
    cap = '0;
    off = 0;
    for (int k = 0; k < nbits; k++) begin
      while (off < k * CPB + CPB / 2) begin
        step();
        off++;
      end
      cap[k] = (which == 0) ? tx0 : tx1;
    end
    while (((which == 0) ? done0 : done1) !== 1'b1 && off < 400) begin
      step();
      off++;
    end
  endtask

  initial begin
    logic [15:0] cap;
    int          off, n, lows, maxc, minr, busyc, d_before;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h55, 10'b1010101010};
    vecs[2] = '{8'h0F, 10'b1000011110};
    vecs[3] = '{8'hFF, 10'b1111111110};
    vecs[4] = '{8'h00, 10'b1000000000};

    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    chk("rst_tx1", tx1, 1'b1);
    chk("rst_ready1", rdy1, 1'b1);
    chk("rst_count1", cnt1, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 5; i++) begin
      v0 = 1'b1;
      d0 = vecs[i].data;
      step();
      v0 = 1'b0;
      chk("tbl_idle_at_push", tx0, 1'b1);
      step();
      chk("tbl_start_latency", tx0, 1'b0);
      capture(0, 10, cap, off);
      chk("tbl_frame", cap, {6'b0, vecs[i].frame});
      chk("tbl_done_offset", off, FLEN0);
      chk("tbl_busy_at_done", busy0, 1'b0);
      step();
      chk("tbl_done_width", done0, 1'b0);
      for (int k = 0; k < 3; k++) step();
    end

    d_before = done0_cnt;
    maxc = 0;
    minr = 1;
    busyc = 0;
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1;
      d0 = (i == 0) ? 8'h55 : (i == 1) ? 8'h0F : (i == 2) ? 8'hFF : 8'h00;
      step();
      if (int'(cnt0) > maxc) maxc = int'(cnt0);
      if (rdy0 !== 1'b1) minr = 0;
      if (busy0 === 1'b1) busyc++;
    end
    v0 = 1'b0;
    for (int i = 0; i < 4 * FLEN0 + 20; i++) begin
      step();
      if (int'(cnt0) > maxc) maxc = int'(cnt0);
      if (busy0 === 1'b1) busyc++;
    end
    chk("b2b_done_count", done0_cnt - d_before, 4);
    chk("b2b_count_peak", maxc, 3);
    chk("b2b_ready_high", minr, 1);
    chk("b2b_busy_cycles", busyc, 4 * FLEN0);

    for (int i = 0; i < 3; i++) begin
      v0 = 1'b1;
      d0 = 8'hC3 + 8'(i);
      step();
    end
    v0 = 1'b0;
    for (int i = 0; i < FLEN0 + 5 * CPB; i++) step();
    chk("mid_busy", busy0, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_tx", tx0, 1'b1);
    chk("arst_count", cnt0, 0);
    chk("arst_busy", busy0, 1'b0);
    chk("arst_ready", rdy0, 1'b1);
    @(negedge clk);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step();
    d_before = done0_cnt;
    lows = 0;
    for (int i = 0; i < 3 * FLEN0; i++) begin
      step();
      if (tx0 !== 1'b1) lows++;
    end
    chk("post_rst_done", done0_cnt - d_before, 0);
    chk("post_rst_line_low", lows, 0);

    for (int i = 0; i < 4000; i++) begin
      n = (i < 1300) ? 2 : (i < 2600) ? 40 : 95;
      v0 = ($urandom_range(0, 99) < n);
      d0 = 8'($urandom);
      step();
    end
    v0 = 1'b0;
    for (int i = 0; i < 5 * FLEN0; i++) step();

    v1 = 1'b1;
    d1 = 7'h03;
    step();
    v1 = 1'b0;
    step();
    chk("p_start_latency", tx1, 1'b0);
    capture(1, 11, cap, off);
    chk("p_frame", cap, 16'b0000011100000110);
    chk("p_done_offset", off, FLEN1);
    for (int i = 0; i < 5; i++) step();

    d_before = done1_cnt;
    maxc = 0;
    v1 = 1'b1;
    d1 = 7'h11;
    step();
    for (int i = 0; i < 6; i++) begin
      d1 = 7'h21 + 7'(i);
      step();
      if (int'(cnt1) > maxc) maxc = int'(cnt1);
    end
    chk("d2_count_full", cnt1, 2);
    chk("d2_ready_low", rdy1, 1'b0);
    v1 = 1'b0;
    for (int i = 0; i < 5 * FLEN1; i++) step();
    chk("d2_count_peak", maxc, 2);
    chk("d2_frames", done1_cnt - d_before, 3);
    chk("d2_idle_count", cnt1, 0);

`ifdef UART_TX_CTS_EN
    cts1 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    v1 = 1'b1;
    d1 = 7'h2A;
    step();
    d1 = 7'h15;
    step();
    v1 = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx1 !== 1'b1) lows++;
    end
    chk("cts_held_line", lows, 0);
    chk("cts_held_count", cnt1, 2);
    cts1 = 1'b0;
    n = 0;
    while (tx1 !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    chk("cts_start_within_3", (n >= 1 && n <= 3), 1);
    off = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      off++;
    end
    cts1 = 1'b1;
    while (done1 !== 1'b1 && off < 400) begin
      step();
      off++;
    end
    chk("cts_frame_completes", off, FLEN1);
    lows = 0;
    for (int i = 0; i < 2 * FLEN1; i++) begin
      step();
      if (tx1 !== 1'b1) lows++;
    end
    chk("cts_second_held", lows, 0);
    chk("cts_second_queued", cnt1, 1);
    cts1 = 1'b0;
    d_before = done1_cnt;
    for (int i = 0; i < FLEN1 + 20; i++) step();
    chk("cts_second_sent", done1_cnt - d_before, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
